// File: rtl/bus_host_arbiter.sv
// Round-robin arbiter sharing one device port among NrHosts bus hosts, with
// request locking and an in-order ID FIFO routing responses back to their host.
module bus_host_arbiter #(
  parameter int unsigned NrHosts        = 2,
  parameter int unsigned AddrWidth      = 32,
  parameter int unsigned DataWidth      = 32,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic                                  clk_sys_i,
  input  logic                                  rst_sys_ni,
  input  logic [NrHosts-1:0]                    host_req_i,
  input  logic [NrHosts-1:0][AddrWidth-1:0]     host_addr_i,
  input  logic [NrHosts-1:0]                    host_we_i,
  input  logic [NrHosts-1:0][DataWidth/8-1:0]   host_be_i,
  input  logic [NrHosts-1:0][DataWidth-1:0]     host_wdata_i,
  output logic [NrHosts-1:0]                    host_gnt_o,
  output logic [NrHosts-1:0]                    host_rvalid_o,
  output logic [NrHosts-1:0][DataWidth-1:0]     host_rdata_o,
  output logic [NrHosts-1:0]                    host_err_o,
  output logic                                  dev_req_o,
  output logic [AddrWidth-1:0]                  dev_addr_o,
  output logic                                  dev_we_o,
  output logic [DataWidth/8-1:0]                dev_be_o,
  output logic [DataWidth-1:0]                  dev_wdata_o,
  input  logic                                  dev_gnt_i,
  input  logic                                  dev_rvalid_i,
  input  logic [DataWidth-1:0]                  dev_rdata_i,
  input  logic                                  dev_err_i,
  output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o,
  output logic                                  spurious_rsp_o
);

  localparam int unsigned IdW  = $clog2(NrHosts);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESENT,
    LOCKED
  } state_e;

  state_e          state_q;
  logic [IdW-1:0]  ptr_q;
  logic [IdW-1:0]  lock_id_q;
  logic [IdW-1:0]  fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q;
  logic [PtrW-1:0] rd_ptr_q;
  logic [CntW-1:0] cnt_q;

  logic [IdW-1:0]  sel;
  logic [IdW-1:0]  cand;
  logic [IdW-1:0]  head;
  logic            found;
  logic            any_req;
  logic            fifo_full;
  logic            handshake;
  logic            pop;

  // A locked host keeps the port only while it still requests; once it drops,
  // ordinary round-robin from the unchanged pointer takes over in that cycle.
  always_comb begin
    sel   = ptr_q;
    cand  = '0;
    found = 1'b0;
    if (state_q == LOCKED && host_req_i[lock_id_q]) begin
      sel = lock_id_q;
    end else begin
      for (int unsigned i = 0; i < NrHosts; i++) begin
        cand = IdW'((32'(ptr_q) + i) % NrHosts);
        if (!found && host_req_i[cand]) begin
          sel   = cand;
          found = 1'b1;
        end
      end
    end
  end

  // Full is taken from the registered count, so a same-cycle pop cannot unblock.
  assign any_req   = |host_req_i;
  assign fifo_full = (cnt_q == CntW'(MaxOutstanding));
  assign dev_req_o = rst_sys_ni & any_req & ~fifo_full;
  assign handshake = dev_req_o & dev_gnt_i;
  assign pop       = rst_sys_ni & dev_rvalid_i & (cnt_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  assign dev_addr_o    = host_addr_i[sel];
  assign dev_we_o      = host_we_i[sel];
  assign dev_be_o      = host_be_i[sel];
  assign dev_wdata_o   = host_wdata_i[sel];
  assign host_rdata_o  = {NrHosts{dev_rdata_i}};
  assign outstanding_o = cnt_q;

  always_comb begin
    host_gnt_o    = '0;
    host_rvalid_o = '0;
    host_err_o    = '0;
    if (handshake) begin
      host_gnt_o[sel] = 1'b1;
    end
    if (pop) begin
      host_rvalid_o[head] = 1'b1;
      host_err_o[head]    = dev_err_i;
    end
  end

  always_ff @(posedge clk_sys_i or negedge rst_sys_ni) begin
    if (!rst_sys_ni) begin
      state_q        <= IDLE;
      ptr_q          <= '0;
      lock_id_q      <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      spurious_rsp_o <= 1'b0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      if (dev_req_o && !dev_gnt_i) begin
        state_q   <= LOCKED;
        lock_id_q <= sel;
      end else if (any_req) begin
        state_q <= PRESENT;
      end else begin
        state_q <= IDLE;
      end

      if (handshake) begin
        ptr_q            <= (sel == IdW'(NrHosts - 1)) ? '0 : sel + 1'b1;
        fifo_q[wr_ptr_q] <= sel;
        wr_ptr_q         <= (wr_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : wr_ptr_q + 1'b1;
      end

      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(MaxOutstanding - 1)) ? '0 : rd_ptr_q + 1'b1;
      end

      case ({handshake, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase

      if (dev_rvalid_i && cnt_q == '0) begin
        spurious_rsp_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bus_host_arbiter.sv
// Bench for bus_host_arbiter: directed vector table, hand-written lock/full/reset
// sequences and random traffic checked against a queue-based reference model.
module tb_bus_host_arbiter;

  localparam int N  = 3;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int MO = 2;
  localparam int CW = $clog2(MO + 1);

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [N-1:0]             host_req;
  logic [N-1:0][AW-1:0]     host_addr;
  logic [N-1:0]             host_we;
  logic [N-1:0][DW/8-1:0]   host_be;
  logic [N-1:0][DW-1:0]     host_wdata;
  logic [N-1:0]             host_gnt;
  logic [N-1:0]             host_rvalid;
  logic [N-1:0][DW-1:0]     host_rdata;
  logic [N-1:0]             host_err;
  logic                     dev_req;
  logic [AW-1:0]            dev_addr;
  logic                     dev_we;
  logic [DW/8-1:0]          dev_be;
  logic [DW-1:0]            dev_wdata;
  logic                     dev_gnt;
  logic                     dev_rvalid;
  logic [DW-1:0]            dev_rdata;
  logic                     dev_err;
  logic [CW-1:0]            outstanding;
  logic                     spurious;

  bus_host_arbiter #(
    .NrHosts       (N),
    .AddrWidth     (AW),
    .DataWidth     (DW),
    .MaxOutstanding(MO)
  ) dut (
    .clk_sys_i     (clk),
    .rst_sys_ni    (rst_n),
    .host_req_i    (host_req),
    .host_addr_i   (host_addr),
    .host_we_i     (host_we),
    .host_be_i     (host_be),
    .host_wdata_i  (host_wdata),
    .host_gnt_o    (host_gnt),
    .host_rvalid_o (host_rvalid),
    .host_rdata_o  (host_rdata),
    .host_err_o    (host_err),
    .dev_req_o     (dev_req),
    .dev_addr_o    (dev_addr),
    .dev_we_o      (dev_we),
    .dev_be_o      (dev_be),
    .dev_wdata_o   (dev_wdata),
    .dev_gnt_i     (dev_gnt),
    .dev_rvalid_i  (dev_rvalid),
    .dev_rdata_i   (dev_rdata),
    .dev_err_i     (dev_err),
    .outstanding_o (outstanding),
    .spurious_rsp_o(spurious)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: arbitration pointer, lock owner and a queue of in-flight host IDs.
  int         ptr_m;
  bit         lock_m;
  logic [1:0] lock_h;
  logic [1:0] q[$];
  bit         spur_m;

  typedef struct {
    logic [N-1:0]  req;
    logic          gnt;
    logic          rv;
    logic          err;
    logic [N-1:0]  e_gnt;
    logic          e_dreq;
    logic [N-1:0]  e_rv;
    logic [N-1:0]  e_err;
    logic [CW-1:0] e_out;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic g, input logic v, input logic e);
    host_req   = r;
    dev_gnt    = g;
    dev_rvalid = v;
    dev_err    = e;
    dev_rdata  = DW'($urandom);
  endtask

  task automatic fixed_fields();
    for (int i = 0; i < N; i++) begin
      host_addr[i]  = AW'(16'h1000 + 16'h0111 * i);
      host_we[i]    = 1'(i);
      host_be[i]    = 2'(i + 1);
      host_wdata[i] = DW'(16'hA000 + i);
    end
  endtask

  task automatic model_reset();
    ptr_m  = 0;
    lock_m = 0;
    lock_h = '0;
    q.delete();
    spur_m = 0;
  endtask

  // Called at a negedge with inputs already driven; ends at the next negedge.
  task automatic step();
    logic [1:0]   s;
    logic [N-1:0] eg;
    logic [N-1:0] er;
    logic [N-1:0] ee;
    bit           found;
    bit           anyr;
    bit           dreq;
    bit           hs;
    bit           pop;
    bit           empty;
    #1;
    anyr  = |host_req;
    found = 0;
    s     = '0;
    if (lock_m && host_req[lock_h]) begin
      s     = lock_h;
      found = 1;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!found && host_req[2'((ptr_m + i) % N)]) begin
          s     = 2'((ptr_m + i) % N);
          found = 1;
        end
      end
    end
    dreq  = anyr && (q.size() < MO);
    hs    = dreq && dev_gnt;
    empty = (q.size() == 0);
    pop   = dev_rvalid && !empty;
    eg    = '0;
    er    = '0;
    ee    = '0;
    if (hs) eg[s] = 1'b1;
    if (pop) begin
      er[q[0]] = 1'b1;
      ee[q[0]] = dev_err;
    end
    check("host_gnt", 64'(host_gnt), 64'(eg));
    check("dev_req", 64'(dev_req), 64'(dreq));
    if (dreq) begin
      check("dev_fields", 64'({dev_addr, dev_we, dev_be, dev_wdata}),
            64'({host_addr[s], host_we[s], host_be[s], host_wdata[s]}));
    end
    check("host_rvalid", 64'(host_rvalid), 64'(er));
    check("host_err", 64'(host_err), 64'(ee));
    check("host_rdata", 64'(host_rdata), 64'({N{dev_rdata}}));
    check("outstanding", 64'(outstanding), 64'(q.size()));
    check("spurious", 64'(spurious), 64'(spur_m));
    if (pop) void'(q.pop_front());
    if (hs) begin
      q.push_back(s);
      ptr_m = (int'(s) + 1) % N;
    end
    lock_m = dreq && !dev_gnt;
    if (lock_m) lock_h = s;
    if (dev_rvalid && empty) spur_m = 1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_and_check();
    rst_n = 1'b0;
    #1;
    check("rst_gnt", 64'(host_gnt), 64'(0));
    check("rst_dev_req", 64'(dev_req), 64'(0));
    check("rst_rvalid", 64'(host_rvalid), 64'(0));
    check("rst_err", 64'(host_err), 64'(0));
    check("rst_outstanding", 64'(outstanding), 64'(0));
    check("rst_spurious", 64'(spurious), 64'(0));
    model_reset();
    drive('0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{3'b011, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000, 2'd0};
    vecs[1]  = '{3'b011, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 3'b001, 3'b000, 2'd1};
    vecs[2]  = '{3'b011, 1'b1, 1'b1, 1'b1, 3'b001, 1'b1, 3'b010, 3'b010, 2'd1};
    vecs[3]  = '{3'b011, 1'b1, 1'b1, 1'b0, 3'b010, 1'b1, 3'b001, 3'b000, 2'd1};
    vecs[4]  = '{3'b011, 1'b1, 1'b0, 1'b0, 3'b001, 1'b1, 3'b000, 3'b000, 2'd1};
    vecs[5]  = '{3'b011, 1'b1, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 2'd2};
    vecs[6]  = '{3'b011, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 3'b010, 3'b000, 2'd2};
    vecs[7]  = '{3'b011, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 3'b000, 3'b000, 2'd1};
    vecs[8]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b001, 3'b000, 2'd2};
    vecs[9]  = '{3'b000, 1'b0, 1'b1, 1'b0, 3'b000, 1'b0, 3'b010, 3'b000, 2'd1};
    vecs[10] = '{3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 3'b000, 3'b000, 2'd0};

    fixed_fields();
    drive('0, 1'b0, 1'b0, 1'b0);
    reset_and_check();

    // Alternating grants, in-order responses, same-cycle push/pop, full blocking.
    foreach (vecs[k]) begin
      drive(vecs[k].req, vecs[k].gnt, vecs[k].rv, vecs[k].err);
      #1;
      check($sformatf("vec%0d_gnt", k), 64'(host_gnt), 64'(vecs[k].e_gnt));
      check($sformatf("vec%0d_dreq", k), 64'(dev_req), 64'(vecs[k].e_dreq));
      check($sformatf("vec%0d_rvalid", k), 64'(host_rvalid), 64'(vecs[k].e_rv));
      check($sformatf("vec%0d_err", k), 64'(host_err), 64'(vecs[k].e_err));
      check($sformatf("vec%0d_out", k), 64'(outstanding), 64'(vecs[k].e_out));
      step();
    end

    // Reset with two transactions in flight.
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    step();
    step();
    drive(3'b011, 1'b1, 1'b1, 1'b0);
    #1;
    check("pre_rst_rvalid", 64'(host_rvalid), 64'(3'b001));
    check("pre_rst_out", 64'(outstanding), 64'(2));
    #1;
    reset_and_check();
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    #1;
    check("post_rst_first_gnt", 64'(host_gnt), 64'(3'b001));
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    step();

    // Lock: host 1 waits without grant, host 0 arrives but cannot preempt.
    reset_and_check();
    drive(3'b010, 1'b0, 1'b0, 1'b0);
    #1;
    check("lock_c1_addr", 64'(dev_addr), 64'(16'h1111));
    step();
    for (int c = 2; c <= 3; c++) begin
      drive(3'b011, 1'b0, 1'b0, 1'b0);
      #1;
      check($sformatf("lock_c%0d_addr", c), 64'(dev_addr), 64'(16'h1111));
      step();
    end
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    #1;
    check("lock_first_gnt", 64'(host_gnt), 64'(3'b010));
    step();
    #1;
    check("lock_second_gnt", 64'(host_gnt), 64'(3'b001));
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    #1;
    check("lock_rsp1", 64'(host_rvalid), 64'(3'b010));
    step();
    #1;
    check("lock_rsp2", 64'(host_rvalid), 64'(3'b001));
    step();

    // Locked host drops its request: lock released, pointer unchanged.
    drive(3'b100, 1'b0, 1'b0, 1'b0);
    step();
    drive(3'b011, 1'b1, 1'b0, 1'b0);
    #1;
    check("drop_release_gnt", 64'(host_gnt), 64'(3'b010));
    step();
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    step();

    // Response with nothing outstanding.
    drive(3'b000, 1'b0, 1'b1, 1'b0);
    #1;
    check("spur_no_rvalid", 64'(host_rvalid), 64'(0));
    step();
    drive(3'b000, 1'b0, 1'b0, 1'b0);
    #1;
    check("spur_set", 64'(spurious), 64'(1));
    check("spur_out_zero", 64'(outstanding), 64'(0));
    step();
    step();
    #1;
    check("spur_sticky", 64'(spurious), 64'(1));

    // Random traffic against the model.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        host_addr[i]  = AW'($urandom);
        host_we[i]    = 1'($urandom);
        host_be[i]    = 2'($urandom);
        host_wdata[i] = DW'($urandom);
      end
      drive(3'($urandom_range(0, 7)), 1'($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 1)));
      step();
    end

    reset_and_check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
